// File: rtl/apb_pkg.sv
// Shared definitions for the APB register completer: FSM state encoding and
// the constants used when deciding whether a transfer must be errored.
// Optional wait-state support is enabled with APB_REG_COMPLETER_WAIT_EN.
package apb_pkg;

    // Two-state completer FSM
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    // The read-only register sits this many entries below NUM_REGS
    localparam int RO_INDEX_OFFSET = 1;

    // Low address bits that must be zero for a word-aligned access
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter for the APB completer. Loaded at SETUP, decremented
// once per ACCESS cycle; o_last flags the cycle whose decrement reaches zero,
// which is where the completer registers pready for the following cycle.
// Only instantiated when APB_REG_COMPLETER_WAIT_EN is defined.
module apb_wait_counter #(
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_last
);

    logic [WIDTH-1:0] r_count;

    // Load takes priority; decrement saturates at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
    assign o_last = (r_count == WIDTH'(1));

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer exposing NUM_REGS data registers; the last one is read-only
// and mirrors ro_in. pready, prdata and pslverr all come straight from flops.
// Define APB_REG_COMPLETER_WAIT_EN to insert WAIT_CYCLES wait states per
// transfer; otherwise every transfer completes in its first ACCESS cycle.
module apb_reg_completer
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                           pclk,
    input  logic                           presetn,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [2:0]                     pprot,
    input  logic                           pnse,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    input  logic [DATA_WIDTH-1:0]          ro_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int IDX_W     = ADDR_WIDTH - 2;
    localparam int REG_IDX_W = (NUM_REGS < 2) ? 1 : $clog2(NUM_REGS);
    localparam logic [REG_IDX_W-1:0] RO_IDX = REG_IDX_W'(NUM_REGS - RO_INDEX_OFFSET);

    apb_state_e r_state;
    apb_state_e w_state_next;

    // Transfer attributes captured at SETUP
    logic [REG_IDX_W-1:0]  r_idx;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NUM_BYTES-1:0]  r_strb;
    logic                  r_err_pend;

    logic                  r_pready;
    logic                  r_pslverr;
    logic [DATA_WIDTH-1:0] r_prdata;

    // Decode of the live bus (valid during SETUP)
    logic [IDX_W-1:0]      w_addr_idx;
    logic [REG_IDX_W-1:0]  w_setup_idx;
    logic                  w_in_range;
    logic                  w_aligned;
    logic                  w_setup_err;

    // Attributes of the transfer in flight, live in IDLE, captured in ACCESS
    logic [REG_IDX_W-1:0]  w_idx_cur;
    logic                  w_write_cur;
    logic                  w_err_cur;

    logic                  w_setup;
    logic                  w_done;
    logic                  w_pready_set;
    logic                  w_commit;
    logic                  w_zero_wait;
    logic                  w_cnt_last;

    logic [DATA_WIDTH-1:0] w_regs_view [NUM_REGS];

    // Protection attributes carry no meaning for this register block
    logic w_unused_prot;
    assign w_unused_prot = ^{pprot, pnse};

    assign w_addr_idx  = paddr[ADDR_WIDTH-1:2];
    assign w_setup_idx = paddr[REG_IDX_W+1:2];
    assign w_in_range  = (w_addr_idx < IDX_W'(NUM_REGS));
    assign w_aligned   = ((paddr[1:0] & ALIGN_MASK) == 2'b00);
    assign w_setup_err = !(w_in_range && w_aligned) || (pwrite && (w_setup_idx == RO_IDX));

    assign w_idx_cur   = (r_state == ST_IDLE) ? w_setup_idx : r_idx;
    assign w_write_cur = (r_state == ST_IDLE) ? pwrite      : r_write;
    assign w_err_cur   = (r_state == ST_IDLE) ? w_setup_err : r_err_pend;

`ifdef APB_REG_COMPLETER_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    logic w_cnt_zero;
    logic w_unused_cnt;

    apb_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_counter (
        .i_clk      (pclk),
        .i_rst_n    (presetn),
        .i_load     (w_setup),
        .i_load_val (CNT_W'(WAIT_CYCLES)),
        .i_dec      (r_state == ST_ACCESS),
        .o_zero     (w_cnt_zero),
        .o_last     (w_cnt_last)
    );

    assign w_unused_cnt = w_cnt_zero;
    assign w_zero_wait  = (WAIT_CYCLES == 0);
`else
    assign w_cnt_last  = 1'b0;
    assign w_zero_wait = 1'b1;
`endif

    // FSM state register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: leave ACCESS on completion or when the requester drops psel
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (psel && !penable) begin
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!psel || r_pready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: SETUP accept, completion edge, and when to raise pready next cycle
    always_comb begin
        w_setup      = 1'b0;
        w_done       = 1'b0;
        w_pready_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_setup      = psel && !penable;
                w_pready_set = psel && !penable && w_zero_wait;
            end
            ST_ACCESS: begin
                w_done       = psel && r_pready;
                w_pready_set = psel && !r_pready && w_cnt_last;
            end
            default: ;
        endcase
    end

    assign w_commit = w_done && r_write && !r_pslverr;

    // Capture address, direction, data, strobes and error decision at SETUP
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_idx      <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_err_pend <= 1'b0;
        end else if (w_setup) begin
            r_idx      <= w_setup_idx;
            r_write    <= pwrite;
            r_wdata    <= pwdata;
            r_strb     <= pstrb;
            r_err_pend <= w_setup_err;
        end
    end

    // Response flops: pulse pready for one cycle with matching data and error
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_pready  <= w_pready_set;
            r_pslverr <= w_pready_set && w_err_cur;
            r_prdata  <= (w_pready_set && !w_write_cur && !w_err_cur)
                         ? w_regs_view[w_idx_cur] : '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == NUM_REGS - RO_INDEX_OFFSET) begin : g_ro
                assign w_regs_view[gi] = ro_in;
            end else begin : g_rw
                logic [DATA_WIDTH-1:0] r_reg;

                // Byte-masked write on the completion edge of a non-errored write
                always_ff @(posedge pclk or negedge presetn) begin
                    if (!presetn) begin
                        r_reg <= '0;
                    end else if (w_commit && (r_idx == REG_IDX_W'(gi))) begin
                        for (int b = 0; b < NUM_BYTES; b++) begin
                            if (r_strb[b]) begin
                                r_reg[b*8 +: 8] <= r_wdata[b*8 +: 8];
                            end
                        end
                    end
                end

                assign w_regs_view[gi] = r_reg;
            end
            assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = w_regs_view[gi];
        end
    endgenerate

    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign prdata  = r_prdata;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed self-checking bench for apb_reg_completer (default parameters).
// Expected latency follows APB_REG_COMPLETER_WAIT_EN when it is defined.
module tb_apb_reg_completer;

    localparam int TB_AW   = 32;
    localparam int TB_DW   = 32;
    localparam int TB_NR   = 8;
    localparam int TB_WAIT = 2;
`ifdef APB_REG_COMPLETER_WAIT_EN
    localparam int EXP_LAT = TB_WAIT + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic                    pclk;
    logic                    presetn;
    logic [TB_AW-1:0]        paddr;
    logic [2:0]              pprot;
    logic                    pnse;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [TB_DW-1:0]        pwdata;
    logic [TB_DW/8-1:0]      pstrb;
    logic                    pready;
    logic [TB_DW-1:0]        prdata;
    logic                    pslverr;
    logic [TB_DW-1:0]        ro_in;
    logic [TB_NR*TB_DW-1:0]  reg_q;

    int n_cmp  = 0;
    int n_fail = 0;

    apb_reg_completer #(
        .ADDR_WIDTH  (TB_AW),
        .DATA_WIDTH  (TB_DW),
        .NUM_REGS    (TB_NR),
        .WAIT_CYCLES (TB_WAIT)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .paddr   (paddr),
        .pprot   (pprot),
        .pnse    (pnse),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .pready  (pready),
        .prdata  (prdata),
        .pslverr (pslverr),
        .ro_in   (ro_in),
        .reg_q   (reg_q)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One APB transfer starting at edge+1; returns with psel low at edge+1
    // after the completion edge, so a following call is back-to-back.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata,
                        output logic err, output int lat);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        @(posedge pclk); #1;
        penable = 1'b1;
        lat = 1;
        while (pready !== 1'b1 && lat < 16) begin
            @(posedge pclk); #1;
            lat++;
        end
        chk("pready_seen", {255'b0, pready}, 256'd1);
        rdata = prdata;
        err   = pslverr;
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        chk("pready_single", {255'b0, pready}, 256'd0);
        chk("prdata_idle", {224'b0, prdata}, 256'd0);
        $display("xfer wr=%0d addr=%h wdata=%h strb=%h -> rdata=%h err=%0d lat=%0d",
                 wr, addr, wdata, strb, rdata, err, lat);
    endtask

    task automatic idle(input int n);
        psel    = 1'b0;
        penable = 1'b0;
        repeat (n) @(posedge pclk);
        #1;
    endtask

    logic [31:0]  rd;
    logic         er;
    int           lt;
    logic [255:0] exp_rw;

    initial begin
        presetn = 1'b0;
        paddr   = '0;
        pprot   = 3'b000;
        pnse    = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        pwdata  = '0;
        pstrb   = '0;
        ro_in   = 32'h12345678;

        // Reset state
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_pready", {255'b0, pready}, 256'd0);
        chk("rst_pslverr", {255'b0, pslverr}, 256'd0);
        chk("rst_prdata", {224'b0, prdata}, 256'd0);
        chk("rst_regs", {32'b0, reg_q[223:0]}, 256'd0);
        presetn = 1'b1;
        idle(1);

        // Full write then read of reg 1
        xfer(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, rd, er, lt);
        chk("wr1_err", {255'b0, er}, 256'd0);
        chk("wr1_lat", 256'(lt), 256'(EXP_LAT));
        chk("wr1_regq", {224'b0, reg_q[63:32]}, {224'b0, 32'hDEADBEEF});
        xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lt);
        chk("rd1_data", {224'b0, rd}, {224'b0, 32'hDEADBEEF});
        chk("rd1_err", {255'b0, er}, 256'd0);
        chk("rd1_lat", 256'(lt), 256'(EXP_LAT));

        // Partial write, byte 1 only
        xfer(1'b1, 32'h4, 32'h0000AA00, 4'h2, rd, er, lt);
        chk("pwr_err", {255'b0, er}, 256'd0);
        chk("pwr_regq", {224'b0, reg_q[63:32]}, {224'b0, 32'hDEADAAEF});

        // Zero strobes: no error, nothing written
        xfer(1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, rd, er, lt);
        chk("strb0_err", {255'b0, er}, 256'd0);
        exp_rw = '0;
        exp_rw[63:32] = 32'hDEADAAEF;
        chk("strb0_regs", {32'b0, reg_q[223:0]}, exp_rw);
        idle(2);

        // Out-of-range read and misaligned write
        xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lt);
        chk("oor_err", {255'b0, er}, 256'd1);
        chk("oor_data", {224'b0, rd}, 256'd0);
        xfer(1'b1, 32'h6, 32'h55555555, 4'hF, rd, er, lt);
        chk("mis_err", {255'b0, er}, 256'd1);
        chk("mis_regs", {32'b0, reg_q[223:0]}, exp_rw);

        // Read-only register: write errors, read returns ro_in
        xfer(1'b1, 32'h1C, 32'hFFFFFFFF, 4'hF, rd, er, lt);
        chk("ro_wr_err", {255'b0, er}, 256'd1);
        chk("ro_regs", {32'b0, reg_q[223:0]}, exp_rw);
        xfer(1'b0, 32'h1C, 32'h0, 4'h0, rd, er, lt);
        chk("ro_rd_err", {255'b0, er}, 256'd0);
        chk("ro_rd_data", {224'b0, rd}, {224'b0, 32'h12345678});
        idle(1);

        // Back-to-back write then read of reg 3, no idle gap
        xfer(1'b1, 32'hC, 32'h11223344, 4'hF, rd, er, lt);
        chk("b2b_wr_err", {255'b0, er}, 256'd0);
        xfer(1'b0, 32'hC, 32'h0, 4'h0, rd, er, lt);
        chk("b2b_rd_data", {224'b0, rd}, {224'b0, 32'h11223344});
        chk("b2b_rd_lat", 256'(lt), 256'(EXP_LAT));
        idle(1);

        // Reset asserted in the middle of a write's ACCESS phase
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h10;
        pwdata  = 32'hCAFEF00D;
        pstrb   = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        #2;
        presetn = 1'b0;
        #1;
        chk("mid_rst_pready", {255'b0, pready}, 256'd0);
        chk("mid_rst_pslverr", {255'b0, pslverr}, 256'd0);
        chk("mid_rst_regs", {32'b0, reg_q[223:0]}, 256'd0);
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        chk("post_rst_pready", {255'b0, pready}, 256'd0);
        chk("post_rst_reg4", {224'b0, reg_q[159:128]}, 256'd0);
        $display("reset mid-access: pready=%0d reg4=%h", pready, reg_q[159:128]);
        idle(1);

        // First transfer after reset release
        xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lt);
        chk("after_rst_data", {224'b0, rd}, 256'd0);
        chk("after_rst_lat", 256'(lt), 256'(EXP_LAT));
        xfer(1'b1, 32'h10, 32'h0BADF00D, 4'hF, rd, er, lt);
        chk("after_rst_wr", {224'b0, reg_q[159:128]}, {224'b0, 32'h0BADF00D});
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
